// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller port between three requesters (0 = video,
// 1 = CPU, 2 = DMA). One access is granted per slot, on a slot_tick seen
// while idle. Port 0 has fixed priority. Ports 1 and 2 alternate when both
// are requesting. After MAX_BUSY back-to-back granted slots, one slot is
// left idle so the controller can auto-refresh.
//
// Handshake: a requester raises reqN with addrN/weN/dinN stable and holds
// them until ackN. ackN is a one-clk pulse, and rdata is valid in that clk
// for reads. The requester drops reqN (or presents a new request) in the
// clk after ackN.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   slot_tick               one-clk pulse at the start of each access slot
//   reqN/addrN/weN/dinN     per-port request, byte address, write flag, data
//   ackN, rdata             per-port completion pulse, read data
//   mem_addr/we/din/oe      controller command, held until the next slot decision
//   mem_dout                controller read data
//   overrun                 sticky: slot_tick arrived while a slot was in progress
//   busy                    a granted access is in progress
//   dbg_state               current FSM state (IDLE/RUN/DONE)
module sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_PHASE = 9,
    parameter int MAX_BUSY   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_tick,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic              we0,
    input  logic              we1,
    input  logic              we2,
    input  logic [7:0]        din0,
    input  logic [7:0]        din1,
    input  logic [7:0]        din2,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_din,
    output logic              mem_oe,
    input  logic [7:0]        mem_dout,
    output logic              overrun,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PH_W = $clog2(DATA_PHASE + 1);
    localparam int BR_W = $clog2(MAX_BUSY + 1);

    state_t            state;
    state_t            state_nxt;
    logic [PH_W-1:0]   phase;
    logic [BR_W-1:0]   busy_run;
    logic              rr_p2;      // 1: port 2 wins the next 1-vs-2 tie
    logic [1:0]        winner;     // port being served, steers ack
    logic              refresh;
    logic              grant;
    logic              tie12;
    logic [1:0]        pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_din;
    logic              sel_we;

    // Arbitration and winner mux.
    always_comb begin
        refresh  = (busy_run == BR_W'(MAX_BUSY));
        tie12    = req1 && req2;
        grant    = 1'b0;
        pick     = 2'd0;
        sel_addr = addr0;
        sel_din  = din0;
        sel_we   = we0;
        if (!refresh) begin
            if (req0) begin
                grant = 1'b1;
                pick  = 2'd0;
            end else if (tie12) begin
                grant = 1'b1;
                pick  = rr_p2 ? 2'd2 : 2'd1;
            end else if (req1) begin
                grant = 1'b1;
                pick  = 2'd1;
            end else if (req2) begin
                grant = 1'b1;
                pick  = 2'd2;
            end
        end
        case (pick)
            2'd1: begin
                sel_addr = addr1;
                sel_din  = din1;
                sel_we   = we1;
            end
            2'd2: begin
                sel_addr = addr2;
                sel_din  = din2;
                sel_we   = we2;
            end
            default: ;
        endcase
    end

    // Next state and per-state outputs.
    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;
        ack2      = 1'b0;
        busy      = 1'b0;
        dbg_state = state;
        case (state)
            IDLE: begin
                if (slot_tick && grant) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (phase == PH_W'(DATA_PHASE)) state_nxt = DONE;
            end
            DONE: begin
                ack0      = (winner == 2'd0);
                ack1      = (winner == 2'd1);
                ack2      = (winner == 2'd2);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            busy_run <= '0;
            rr_p2    <= 1'b0;
            winner   <= 2'd0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_din  <= 8'h00;
            rdata    <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            // A tick outside IDLE means the slot period is too short.
            if (slot_tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (slot_tick) begin
                        if (grant) begin
                            mem_addr <= sel_addr;
                            mem_din  <= sel_din;
                            mem_we   <= sel_we;
                            mem_oe   <= ~sel_we;
                            winner   <= pick;
                            phase    <= '0;
                            // A grant is only possible below MAX_BUSY, so
                            // the increment saturates at MAX_BUSY.
                            busy_run <= busy_run + 1'b1;
                            if (pick != 2'd0 && tie12) rr_p2 <= ~rr_p2;
                        end else begin
                            // Refresh or empty slot: the controller sees no
                            // command and the busy run restarts.
                            mem_we   <= 1'b0;
                            mem_oe   <= 1'b0;
                            busy_run <= '0;
                        end
                    end
                end
                RUN: begin
                    phase <= phase + 1'b1;
                    if (phase == PH_W'(DATA_PHASE) && mem_oe) rdata <= mem_dout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int ADDR_W     = 25;
  localparam int DATA_PHASE = 9;
  localparam int MAX_BUSY   = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, slot_tick;
  logic              req0, req1, req2, we0, we1, we2;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [7:0]        din0, din1, din2;
  logic              ack0, ack1, ack2;
  logic [7:0]        rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_oe, overrun, busy;
  logic [1:0]        dbg_state;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_PHASE(DATA_PHASE), .MAX_BUSY(MAX_BUSY)) dut (
    .clk(clk), .reset(reset), .slot_tick(slot_tick),
    .req0(req0), .req1(req1), .req2(req2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .we0(we0), .we1(we1), .we2(we2),
    .din0(din0), .din1(din1), .din2(din2),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_oe(mem_oe),
    .mem_dout(mem_dout), .overrun(overrun), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- controller memory (1 KB, mirrored) ----------------
  logic [7:0] ctl_mem [1024];
  logic [7:0] ref_mem [1024];
  logic       mem_init, pre_en;
  logic [9:0] pre_addr;
  logic [7:0] pre_data;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) ctl_mem[i] <= pat(i);
    end else if (pre_en) begin
      ctl_mem[pre_addr] <= pre_data;
    end else if (busy && mem_we) begin
      ctl_mem[mem_addr[9:0]] <= mem_din;
    end
  end
  assign mem_dout = mem_oe ? ctl_mem[mem_addr[9:0]] : 8'h00;

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  logic              pend  [3];
  logic [ADDR_W-1:0] paddr [3];
  logic              pwe   [3];
  logic [7:0]        pdin  [3];
  logic [7:0]        exp_rd;
  int                m_run, m_rr;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ports();
    req0 = pend[0]; addr0 = paddr[0]; we0 = pwe[0]; din0 = pdin[0];
    req1 = pend[1]; addr1 = paddr[1]; we1 = pwe[1]; din1 = pdin[1];
    req2 = pend[2]; addr2 = paddr[2]; we2 = pwe[2]; din2 = pdin[2];
  endtask

  task automatic new_req(input int p);
    pend[p]  = 1'b1;
    paddr[p] = {15'($urandom_range(0, 7)), 10'($urandom_range(0, 31))};
    pwe[p]   = 1'($urandom_range(0, 1));
    pdin[p]  = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    slot_tick = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pend[p] = 1'b0; paddr[p] = '0; pwe[p] = 1'b0; pdin[p] = 8'h00;
    end
    drive_ports();
    step();
    step();
    reset = 1'b0;
    m_run = 0;
    m_rr = 1;
    exp_rd = 8'h00;
  endtask

  // Reference arbiter: which port a slot serves, -1 for an empty/refresh slot.
  task automatic model_pick(input logic [2:0] r, output int win);
    if (m_run == MAX_BUSY) begin
      win = -1;
      m_run = 0;
    end else begin
      if (r[0]) win = 0;
      else if (r[1] && r[2]) begin
        win = m_rr;
        m_rr = 3 - m_rr;
      end else if (r[1]) win = 1;
      else if (r[2]) win = 2;
      else win = -1;
      if (win < 0) m_run = 0;
      else m_run = (m_run + 1 > MAX_BUSY) ? MAX_BUSY : m_run + 1;
    end
  endtask

  // Issues one tick, snapshots the controller command after the grant edge,
  // then waits (bounded) for an ack. ap: -1 none, 0..2 port, 3 several acks.
  // lat counts clks from the grant edge to the ack.
  task automatic run_slot(output int ap, output int lat, output logic [7:0] rd,
                          output logic s_we, output logic s_oe,
                          output logic [ADDR_W-1:0] s_addr, output logic [7:0] s_din,
                          output logic s_busy);
    step();
    slot_tick = 1'b1;
    step();
    slot_tick = 1'b0;
    s_we = mem_we; s_oe = mem_oe; s_addr = mem_addr; s_din = mem_din; s_busy = busy;
    ap = -1; lat = 0; rd = 8'h00;
    for (int k = 1; k <= DATA_PHASE + 2; k++) begin
      step();
      if (ack0 || ack1 || ack2) begin
        if (int'(ack0) + int'(ack1) + int'(ack2) > 1) ap = 3;
        else ap = ack0 ? 0 : (ack1 ? 1 : 2);
        lat = k;
        rd = rdata;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    checks++; if (mem_oe !== 1'b0) begin errors++; $display("FAIL reset_mem_oe got %0b exp 0", mem_oe); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %0h exp 0", mem_din); end
    checks++; if ({ack2, ack1, ack0} !== 3'b000) begin errors++; $display("FAIL reset_ack got %b exp 000", {ack2, ack1, ack0}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %0h exp 0", rdata); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
  endtask

  task automatic test_single_read();
    int ap, lat, win;
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    pre_en = 1'b1; pre_addr = 10'h123; pre_data = 8'h5A;
    step();
    pre_en = 1'b0;
    ref_mem[10'h123] = 8'h5A;
    pend[1] = 1'b1; paddr[1] = 25'h000123; pwe[1] = 1'b0; pdin[1] = 8'h00;
    drive_ports();
    model_pick(3'b010, win);
    run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
    checks++; if (s_oe !== 1'b1 || s_we !== 1'b0) begin errors++; $display("FAIL read_cmd got oe=%0b we=%0b exp oe=1 we=0", s_oe, s_we); end
    checks++; if (s_addr !== 25'h000123) begin errors++; $display("FAIL read_addr got %0h exp 123", s_addr); end
    checks++; if (ap !== 1) begin errors++; $display("FAIL read_ack_port got %0d exp 1", ap); end
    checks++; if (lat !== DATA_PHASE + 1) begin errors++; $display("FAIL read_latency got %0d exp %0d", lat, DATA_PHASE + 1); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL read_rdata got %0h exp 5a", rd); end
    exp_rd = 8'h5A;
    pend[1] = 1'b0;
    drive_ports();
  endtask

  task automatic test_write_readback();
    int ap, lat, win;
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    pend[2] = 1'b1; paddr[2] = 25'h1ABCDE; pwe[2] = 1'b1; pdin[2] = 8'hC3;
    drive_ports();
    model_pick(3'b100, win);
    run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
    checks++; if (s_we !== 1'b1 || s_oe !== 1'b0) begin errors++; $display("FAIL wr_cmd got we=%0b oe=%0b exp we=1 oe=0", s_we, s_oe); end
    checks++; if (s_din !== 8'hC3) begin errors++; $display("FAIL wr_din got %0h exp c3", s_din); end
    checks++; if (s_addr !== 25'h1ABCDE) begin errors++; $display("FAIL wr_addr got %0h exp 1abcde", s_addr); end
    checks++; if (ap !== 2 || lat !== DATA_PHASE + 1) begin errors++; $display("FAIL wr_ack got port %0d lat %0d exp port 2 lat %0d", ap, lat, DATA_PHASE + 1); end
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL wr_rdata_kept got %0h exp %0h", rd, exp_rd); end
    ref_mem[10'h0DE] = 8'hC3;
    pwe[2] = 1'b0;
    drive_ports();
    model_pick(3'b100, win);
    run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
    checks++; if (s_oe !== 1'b1 || s_we !== 1'b0) begin errors++; $display("FAIL rb_cmd got oe=%0b we=%0b exp oe=1 we=0", s_oe, s_we); end
    checks++; if (ap !== 2 || lat !== DATA_PHASE + 1) begin errors++; $display("FAIL rb_ack got port %0d lat %0d exp port 2 lat %0d", ap, lat, DATA_PHASE + 1); end
    checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL rb_rdata got %0h exp c3", rd); end
    exp_rd = 8'hC3;
    pend[2] = 1'b0;
    drive_ports();
  endtask

  task automatic test_priority_rr();
    int ap, lat, w;
    int exp_order [7] = '{0, 0, 0, 1, 2, 1, 2};
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    for (int p = 0; p < 3; p++) new_req(p);
    drive_ports();
    for (int s = 0; s < 7; s++) begin
      if (s == 3) begin
        pend[0] = 1'b0;
        drive_ports();
      end
      w = exp_order[s];
      run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
      checks++; if (ap !== w) begin errors++; $display("FAIL prio_order slot %0d got %0d exp %0d", s, ap, w); end
      checks++; if (lat !== DATA_PHASE + 1 || s_addr !== paddr[w]) begin errors++; $display("FAIL prio_grant slot %0d got lat %0d addr %0h exp lat %0d addr %0h", s, lat, s_addr, DATA_PHASE + 1, paddr[w]); end
      if (pwe[w]) ref_mem[paddr[w][9:0]] = pdin[w];
      else exp_rd = ref_mem[paddr[w][9:0]];
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL prio_rdata slot %0d got %0h exp %0h", s, rd, exp_rd); end
      new_req(w);
      if (s >= 2 && w == 0) pend[0] = 1'b0;
      drive_ports();
    end
    for (int p = 0; p < 3; p++) pend[p] = 1'b0;
    drive_ports();
  endtask

  // Random request traffic checked slot by slot against the reference model.
  task automatic test_traffic(input int n, input int p0_pct, input int p12_pct, output int idle_cnt);
    int ap, lat, win;
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    idle_cnt = 0;
    for (int s = 0; s < n; s++) begin
      for (int p = 0; p < 3; p++)
        if (!pend[p] && $urandom_range(0, 99) < ((p == 0) ? p0_pct : p12_pct)) new_req(p);
      drive_ports();
      model_pick({pend[2], pend[1], pend[0]}, win);
      run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
      if (ap < 0) idle_cnt++;
      checks++; if (ap !== win) begin errors++; $display("FAIL traffic_ack slot %0d got %0d exp %0d", s, ap, win); end
      checks++; if (s_we && s_oe) begin errors++; $display("FAIL traffic_we_oe slot %0d got we=1 oe=1 exp not both", s); end
      if (win >= 0) begin
        checks++;
        if (lat !== DATA_PHASE + 1 || s_addr !== paddr[win] || s_we !== pwe[win] || s_busy !== 1'b1) begin
          errors++;
          $display("FAIL traffic_grant slot %0d got lat %0d addr %0h we %0b busy %0b exp lat %0d addr %0h we %0b busy 1",
                   s, lat, s_addr, s_we, s_busy, DATA_PHASE + 1, paddr[win], pwe[win]);
        end
        if (pwe[win]) begin
          checks++; if (s_din !== pdin[win]) begin errors++; $display("FAIL traffic_din slot %0d got %0h exp %0h", s, s_din, pdin[win]); end
          ref_mem[paddr[win][9:0]] = pdin[win];
        end else begin
          exp_rd = ref_mem[paddr[win][9:0]];
        end
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL traffic_rdata slot %0d got %0h exp %0h", s, rd, exp_rd); end
        pend[win] = 1'b0;
        drive_ports();
      end else begin
        checks++; if (s_we !== 1'b0 || s_oe !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL traffic_idle slot %0d got we=%0b oe=%0b busy=%0b exp 0 0 0", s, s_we, s_oe, s_busy); end
      end
    end
    for (int p = 0; p < 3; p++) pend[p] = 1'b0;
    drive_ports();
  endtask

  task automatic test_refresh();
    int idle_cnt;
    // Ports 1 and 2 always pending: 20 ticks give grants 0-7, refresh at 8,
    // grants 9-16, refresh at 17, grants 18-19.
    test_traffic(20, 50, 100, idle_cnt);
    checks++; if (idle_cnt !== 2) begin errors++; $display("FAIL refresh_count got %0d exp 2", idle_cnt); end
  endtask

  task automatic test_random();
    int idle_cnt;
    test_traffic(40, 25, 40, idle_cnt);
  endtask

  task automatic test_overrun();
    int ap, lat;
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    pend[1] = 1'b1; paddr[1] = 25'h0000AB; pwe[1] = 1'b0; pdin[1] = 8'h00;
    pend[2] = 1'b1; paddr[2] = 25'h000155; pwe[2] = 1'b1; pdin[2] = 8'h77;
    drive_ports();
    step();
    slot_tick = 1'b1;
    step();
    slot_tick = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %0b exp 0", overrun); end
    step(); step(); step();
    slot_tick = 1'b1;
    step();
    slot_tick = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b exp 1", overrun); end
    checks++; if (mem_addr !== 25'h0000AB || busy !== 1'b1) begin errors++; $display("FAIL ovr_no_regrant got addr %0h busy %0b exp addr ab busy 1", mem_addr, busy); end
    ap = -1; lat = 0; rd = 8'h00;
    for (int k = 5; k <= DATA_PHASE + 3; k++) begin
      step();
      if (ack0 || ack1 || ack2) begin
        if (int'(ack0) + int'(ack1) + int'(ack2) > 1) ap = 3;
        else ap = ack0 ? 0 : (ack1 ? 1 : 2);
        lat = k;
        rd = rdata;
        break;
      end
    end
    exp_rd = ref_mem[10'h0AB];
    checks++; if (ap !== 1 || lat !== DATA_PHASE + 1) begin errors++; $display("FAIL ovr_ack got port %0d lat %0d exp port 1 lat %0d", ap, lat, DATA_PHASE + 1); end
    checks++; if (rd !== exp_rd) begin errors++; $display("FAIL ovr_rdata got %0h exp %0h", rd, exp_rd); end
    pend[1] = 1'b0;
    drive_ports();
    run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
    checks++; if (ap !== 2 || s_we !== 1'b1 || s_din !== 8'h77) begin errors++; $display("FAIL ovr_next got port %0d we %0b din %0h exp port 2 we 1 din 77", ap, s_we, s_din); end
    ref_mem[10'h155] = 8'h77;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", overrun); end
    pend[2] = 1'b0;
    drive_ports();
    apply_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %0b exp 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int ap, lat, ack_seen;
    logic [7:0] rd, s_din;
    logic s_we, s_oe, s_busy;
    logic [ADDR_W-1:0] s_addr;
    apply_reset();
    pend[1] = 1'b1; paddr[1] = 25'h0003C0; pwe[1] = 1'b0; pdin[1] = 8'h00;
    drive_ports();
    step();
    slot_tick = 1'b1;
    step();
    slot_tick = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++; if (busy !== 1'b1 || mem_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_active got busy %0b oe %0b exp 1 1", busy, mem_oe); end
    reset = 1'b1;
    step();
    checks++;
    if (mem_addr !== '0 || mem_we !== 1'b0 || mem_oe !== 1'b0 || mem_din !== 8'h00 ||
        {ack2, ack1, ack0} !== 3'b000 || rdata !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got addr %0h we %0b oe %0b din %0h ack %b rdata %0h busy %0b ovr %0b exp all 0",
               mem_addr, mem_we, mem_oe, mem_din, {ack2, ack1, ack0}, rdata, busy, overrun);
    end
    reset = 1'b0;
    m_run = 0; m_rr = 1; exp_rd = 8'h00;
    ack_seen = 0;
    for (int k = 0; k < DATA_PHASE + 3; k++) begin
      step();
      if (ack0 || ack1 || ack2) ack_seen++;
    end
    checks++; if (ack_seen !== 0) begin errors++; $display("FAIL rst_mid_no_ack got %0d acks exp 0", ack_seen); end
    run_slot(ap, lat, rd, s_we, s_oe, s_addr, s_din, s_busy);
    exp_rd = ref_mem[10'h3C0];
    checks++; if (ap !== 1 || lat !== DATA_PHASE + 1) begin errors++; $display("FAIL rst_mid_reserve got port %0d lat %0d exp port 1 lat %0d", ap, lat, DATA_PHASE + 1); end
    checks++; if (rd !== exp_rd || s_addr !== 25'h0003C0) begin errors++; $display("FAIL rst_mid_rdata got %0h addr %0h exp %0h addr 3c0", rd, s_addr, exp_rd); end
    pend[1] = 1'b0;
    drive_ports();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; slot_tick = 1'b0;
    mem_init = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = 8'h00;
    for (int p = 0; p < 3; p++) begin
      pend[p] = 1'b0; paddr[p] = '0; pwe[p] = 1'b0; pdin[p] = 8'h00;
    end
    drive_ports();
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    step();
    mem_init = 1'b0;

    test_reset();
    test_single_read();
    test_write_readback();
    test_priority_rr();
    test_refresh();
    test_random();
    test_overrun();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single 8-bit SDRAM controller port between three requesters: port 0 video fetch, port 1 CPU, port 2 DMA. Grants are made once per SDRAM access slot, aligned to a slot_tick pulse from the system clock-sync logic. The block drives the controller's address, write-enable, write-data and output-enable inputs, and returns read data with a per-port acknowledge. It also guarantees periodic idle slots, so the controller issues auto-refresh even under continuous load.

Parameters:
ADDR_W, 25, byte address width passed to the controller
DATA_PHASE, 9, clocks after the grant edge at which mem_dout is sampled (must lie after the controller's read-capture point)
MAX_BUSY, 8, maximum consecutive granted slots before a refresh (idle) slot is forced

Ports:
clk  in  1  system/SDRAM state-machine clock
reset  in  1  synchronous, active-high reset
slot_tick  in  1  one-clk pulse marking the start of each SDRAM access slot
req0, req1, req2  in  1 each  request; held high with address/data stable until the matching ack
addr0, addr1, addr2  in  ADDR_W each  byte address per port
we0, we1, we2  in  1 each  1 = write, 0 = read
din0, din1, din2  in  8 each  write data per port
ack0, ack1, ack2  out  1 each  one-clk completion pulse
rdata  out  8  read data, valid in the ack cycle of a read
mem_addr  out  ADDR_W  to controller addr
mem_we  out  1  to controller we
mem_din  out  8  to controller din
mem_oe  out  1  to controller read enable
mem_dout  in  8  controller read data
overrun  out  1  sticky: slot_tick arrived while a slot was still in progress
busy  out  1  a granted access is in progress

Behaviour:
- Reset values: mem_addr=0, mem_we=0, mem_oe=0, mem_din=0, ack*=0, rdata=0, overrun=0, busy=0. Internal state: IDLE, phase=0, busy_run=0, rr pointer=port 1.
- Reset mid-slot: all outputs return to reset values on that edge. The in-flight access is never acked. Requesters keep req high and are re-served after reset.
- States:
  - IDLE: waits for slot_tick.
  - RUN: phase counter active.
  - DONE: single clk; issues ack, then returns to IDLE.
- Arbitration, evaluated only in a clk with slot_tick=1 while in IDLE:
  - If busy_run==MAX_BUSY: force a refresh slot. mem_we=mem_oe=0, no grant, busy_run cleared, stay IDLE.
  - Else req0 wins.
  - Else, if exactly one of req1/req2 is high, that port wins.
  - Else, if both are high, the port selected by rr wins. rr then points at the other port. Granting port 0 leaves rr unchanged.
  - If no req is high: idle slot, mem_we=mem_oe=0, busy_run cleared.
- Grant actions, on the edge ending the tick cycle:
  - mem_addr/mem_din/mem_we are loaded from the winner; mem_oe = ~we of the winner.
  - busy=1, phase=0, busy_run increments (saturating at MAX_BUSY), go to RUN.
  - Outputs to the controller stay stable until the next slot decision.
- RUN: phase increments each clk. At phase==DATA_PHASE, rdata is captured from mem_dout (reads only; rdata is unchanged for writes) and the state moves to DONE.
- DONE: the winner's ack pulses for exactly one clk with rdata valid. busy=0. Go to IDLE.
- Latency: grant edge to ack = DATA_PHASE+1 clks.
- A requester must drop req (or present a new request) the clk after ack. The acked port is not re-granted by a tick coinciding with DONE, because ticks are only sampled in IDLE.
- slot_tick while in RUN or DONE: ignored, no grant, overrun set to 1 and held until reset. The access in progress completes normally.
- Slot period ≥ DATA_PHASE+3 clks is a system requirement.
- Only one ack* is ever high in a given clk.
- mem_we and mem_oe are never both 1.

Test Plan:
- Single read: req1=1, we1=0, addr1=0x000123, mem_dout model returns 0x5A; tick → mem_oe=1, mem_addr=0x000123 one clk after tick; ack1 and rdata=0x5A exactly DATA_PHASE+1 clks after grant edge.
- Write then read-back on port 2: write 0xC3 to 0x1ABCDE, then read the same address → mem_we=1/mem_din=0xC3 in the first slot; ack2 and rdata=0xC3 in the second.
- Priority and round-robin: req0, req1 and req2 held high continuously with re-requests → grant order 0,0,0… while req0 is high. After req0 drops, order is 1,2,1,2; ack* are never simultaneous.
- Refresh forcing: all ports requesting continuously for 20 ticks → after every 8 granted slots, one slot has mem_we=mem_oe=0 and no ack; 9-slot pattern repeats.
- Overrun: second slot_tick issued 4 clks after a grant → no new grant, overrun=1 and sticky; the original ack still occurs on time.
- Reset mid-access: assert reset at phase 5 of a port-1 read → all outputs zero the next clk, no ack1; after reset release and a tick, port 1 is granted and acked normally.
